// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: picorv32 native memory port to strobe-based system bus.
// Adds per-region latency, wait extension with timeout capture, and halt hold.
module cpu_mem_bridge #(
  parameter int unsigned address_width  = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter logic [31:0] SLOW_BASE      = 32'h0000_8000,
  parameter logic [31:0] SLOW_MASK      = 32'hFFFF_F000,
  parameter int unsigned SLOW_LATENCY   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     cpu_mem_valid_i,
  input  logic [31:0]              cpu_mem_addr_i,
  input  logic [31:0]              cpu_mem_wdata_i,
  input  logic [3:0]               cpu_mem_wstrb_i,
  output logic                     cpu_mem_ready_o,
  output logic [31:0]              cpu_mem_rdata_o,
  input  logic                     halt_i,
  output logic [address_width-1:0] bus_address_o,
  output logic                     bus_addr_strb_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_we_ram_o,
  output logic [31:0]              bus_data_o,
  input  logic [31:0]              bus_data_i,
  input  logic                     bus_wait_i,
  output logic                     err_o,
  output logic [31:0]              err_addr_o,
  input  logic                     err_clr_i
);

  typedef enum logic [2:0] {
    IDLE, STRB, WAIT, RESP, GAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_lat;
  logic [3:0]  r_cnt;
  logic [7:0]  r_tcnt;
  logic        r_err;
  logic [31:0] r_err_addr;

  logic w_accept;
  logic w_slow;
  logic w_sample;
  logic w_done;
  logic w_tout;
  logic w_write;

  assign w_accept = (r_state == IDLE) && cpu_mem_valid_i && !halt_i;
  assign w_slow   = (cpu_mem_addr_i & SLOW_MASK) == SLOW_BASE;
  assign w_write  = |r_wstrb;
  assign w_sample = ((r_state == STRB) && (r_lat == 4'd1)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd1));
  assign w_done   = w_sample && !bus_wait_i;
  assign w_tout   = w_sample && bus_wait_i &&
                    (r_tcnt == 8'(TIMEOUT_CYCLES));

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = STRB;
      STRB: w_next = (w_done || w_tout) ? RESP : WAIT;
      WAIT: if (w_done || w_tout) w_next = RESP;
      RESP: if (!halt_i) w_next = GAP;
      GAP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture, latency countdown, wait counting and data capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_lat   <= '0;
      r_cnt   <= '0;
      r_tcnt  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_mem_addr_i;
        r_wdata <= cpu_mem_wdata_i;
        r_wstrb <= cpu_mem_wstrb_i;
        r_lat   <= w_slow ? 4'(SLOW_LATENCY) : 4'(READ_LATENCY);
        r_tcnt  <= '0;
      end
      if (r_state == STRB)
        r_cnt <= (r_lat == 4'd1) ? 4'd1 : r_lat - 4'd1;
      else if (r_state == WAIT && r_cnt != 4'd1)
        r_cnt <= r_cnt - 4'd1;
      if (w_sample && bus_wait_i && !w_tout)
        r_tcnt <= r_tcnt + 8'd1;
      if (w_done)
        r_rdata <= w_write ? 32'h0 : bus_data_i;
      else if (w_tout)
        r_rdata <= w_write ? 32'h0 : ERR_DATA;
    end
  end

  // Sticky timeout flag; a timeout beats a same-cycle clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_tout) begin
      r_err <= 1'b1;
      if (!r_err || err_clr_i) r_err_addr <= r_addr;
    end else if (err_clr_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end
  end

  // Bus and core outputs decoded from state so reset zeroes them at once.
  always_comb begin
    bus_addr_strb_o = (r_state == STRB);
    bus_address_o   = bus_addr_strb_o ? r_addr[address_width-1:0] : '0;
    bus_we_o        = bus_addr_strb_o && w_write;
    bus_we_ram_o    = bus_addr_strb_o ? r_wstrb : 4'h0;
    bus_data_o      = (r_state == STRB || r_state == WAIT ||
                       r_state == RESP) ? r_wdata : 32'h0;
    cpu_mem_ready_o = (r_state == RESP) && !halt_i;
    cpu_mem_rdata_o = cpu_mem_ready_o ? r_rdata : 32'h0;
    err_o           = r_err;
    err_addr_o      = r_err_addr;
  end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: directed checks of latency, windows, waits,
// timeout capture, halt holding and asynchronous reset.
module tb_cpu_mem_bridge;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cpu_mem_valid_i;
  logic [31:0] cpu_mem_addr_i;
  logic [31:0] cpu_mem_wdata_i;
  logic [3:0]  cpu_mem_wstrb_i;
  logic        cpu_mem_ready_o;
  logic [31:0] cpu_mem_rdata_o;
  logic        halt_i;
  logic [31:0] bus_address_o;
  logic        bus_addr_strb_o;
  logic        bus_we_o;
  logic [3:0]  bus_we_ram_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_wait_i;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_clr_i;

  int errors = 0;
  int checks = 0;

  int w_from = 0;
  int w_to   = 0;
  int h_from = 0;
  int h_to   = 0;
  int z_from = 1000;

  int          lat;
  int          sc;
  int          wc;
  int          dbad;
  logic [31:0] rd;
  logic [31:0] sa;
  logic [3:0]  swe;

  cpu_mem_bridge #(
    .address_width (32),
    .READ_LATENCY  (1),
    .SLOW_BASE     (32'h0000_8000),
    .SLOW_MASK     (32'hFFFF_F000),
    .SLOW_LATENCY  (4),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .cpu_mem_valid_i(cpu_mem_valid_i),
    .cpu_mem_addr_i (cpu_mem_addr_i),
    .cpu_mem_wdata_i(cpu_mem_wdata_i),
    .cpu_mem_wstrb_i(cpu_mem_wstrb_i),
    .cpu_mem_ready_o(cpu_mem_ready_o),
    .cpu_mem_rdata_o(cpu_mem_rdata_o),
    .halt_i         (halt_i),
    .bus_address_o  (bus_address_o),
    .bus_addr_strb_o(bus_addr_strb_o),
    .bus_we_o       (bus_we_o),
    .bus_we_ram_o   (bus_we_ram_o),
    .bus_data_o     (bus_data_o),
    .bus_data_i     (bus_data_i),
    .bus_wait_i     (bus_wait_i),
    .err_o          (err_o),
    .err_addr_o     (err_addr_o),
    .err_clr_i      (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Present one request at a negedge and count cycles until ready.
  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws);
    @(negedge clk_i);
    cpu_mem_valid_i = 1'b1;
    cpu_mem_addr_i  = a;
    cpu_mem_wdata_i = wd;
    cpu_mem_wstrb_i = ws;
    bus_wait_i      = 1'b0;
    #1;
    lat = -1; sc = 0; wc = 0; dbad = 0;
    rd = '0; sa = '0; swe = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_i);
      bus_wait_i = (i >= w_from) && (i < w_to);
      halt_i     = (i >= h_from) && (i < h_to);
      if (i >= z_from) bus_data_i = 32'h0;
      #1;
      if (bus_addr_strb_o) begin
        sc++; sa = bus_address_o; swe = bus_we_ram_o;
      end
      if (bus_we_o) wc++;
      if (bus_data_o !== wd) dbad++;
      if (cpu_mem_ready_o) begin
        lat = i; rd = cpu_mem_rdata_o;
        break;
      end
    end
    bus_wait_i = 1'b0;
    halt_i     = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk_i);
    cpu_mem_valid_i = 1'b0;
    cpu_mem_wstrb_i = 4'h0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({cpu_mem_ready_o, cpu_mem_rdata_o, bus_address_o, bus_addr_strb_o,
         bus_we_o, bus_we_ram_o, bus_data_o, err_o, err_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero output, want all 0");
    end
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_read();
    bus_data_i = 32'h1234_5678;
    access(32'h0000_0100, 32'h0, 4'h0);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL read_lat: got %0d want 2", lat);
    end
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++; $display("FAIL read_data: got %h want 12345678", rd);
    end
    checks++;
    if (sa !== 32'h100) begin
      errors++; $display("FAIL read_addr: got %h want 00000100", sa);
    end
    checks++;
    if (wc !== 0) begin
      errors++; $display("FAIL read_we: got %0d pulses want 0", wc);
    end
    checks++;
    if (sc !== 1) begin
      errors++; $display("FAIL read_strb: got %0d strobes want 1", sc);
    end
    idle();
  endtask

  task automatic test_write();
    access(32'h0000_0200, 32'hA5A5_A5A5, 4'b0011);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL write_lat: got %0d want 2", lat);
    end
    checks++;
    if (sc !== 1 || wc !== 1) begin
      errors++;
      $display("FAIL write_pulses: got strb=%0d we=%0d want 1/1", sc, wc);
    end
    checks++;
    if (sa !== 32'h200 || swe !== 4'b0011) begin
      errors++;
      $display("FAIL write_addr_be: got %h/%b want 00000200/0011", sa, swe);
    end
    checks++;
    if (dbad !== 0) begin
      errors++; $display("FAIL write_data_hold: got %0d bad cycles want 0", dbad);
    end
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL write_rdata: got %h want 0", rd);
    end
    idle();
  endtask

  task automatic test_slow_back_to_back();
    bus_data_i = 32'h0BAD_F00D;
    access(32'h0000_8010, 32'h0, 4'h0);
    checks++;
    if (lat !== 5 || rd !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL slow_read: got lat=%0d data=%h want 5/0badf00d", lat, rd);
    end
    bus_data_i = 32'h0000_0077;
    access(32'h0000_0010, 32'h0, 4'h0);
    checks++;
    if (lat !== 3 || rd !== 32'h77) begin
      errors++;
      $display("FAIL back_to_back: got lat=%0d data=%h want 3/00000077", lat, rd);
    end
    idle();
    access(32'h0000_9000, 32'h0, 4'h0);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL window_above: got %0d want 2", lat);
    end
    idle();
    access(32'h0000_8FFC, 32'h0, 4'h0);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL window_top: got %0d want 5", lat);
    end
    idle();
  endtask

  task automatic test_wait();
    bus_data_i = 32'h0000_00FF;
    w_from = 1; w_to = 4;
    access(32'h0000_0400, 32'h0, 4'h0);
    w_to = 0;
    checks++;
    if (lat !== 5 || rd !== 32'hFF) begin
      errors++;
      $display("FAIL wait_ext: got lat=%0d data=%h want 5/000000ff", lat, rd);
    end
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL wait_err: got %b want 0", err_o);
    end
    idle();
  endtask

  task automatic test_timeout();
    bus_data_i = 32'h1111_1111;
    w_from = 1; w_to = 1000;
    access(32'h0000_0300, 32'h0, 4'h0);
    checks++;
    if (lat !== 10 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL timeout_resp: got lat=%0d data=%h want 10/deadbeef", lat, rd);
    end
    checks++;
    if (err_o !== 1'b1 || err_addr_o !== 32'h300) begin
      errors++;
      $display("FAIL timeout_err: got %b/%h want 1/00000300", err_o, err_addr_o);
    end
    idle();
    access(32'h0000_8040, 32'h0, 4'h0);
    checks++;
    if (lat !== 13) begin
      errors++; $display("FAIL timeout2_lat: got %0d want 13", lat);
    end
    checks++;
    if (err_addr_o !== 32'h300) begin
      errors++; $display("FAIL timeout2_keep: got %h want 00000300", err_addr_o);
    end
    w_to = 0;
    idle();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL err_clear: got %b/%h want 0/00000000", err_o, err_addr_o);
    end
  endtask

  task automatic test_halt();
    bus_data_i = 32'hCAFE_0001;
    h_from = 3; h_to = 8; z_from = 5;
    access(32'h0000_8000, 32'h0, 4'h0);
    h_to = 0; z_from = 1000;
    checks++;
    if (lat !== 8 || rd !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL halt_hold: got lat=%0d data=%h want 8/cafe0001", lat, rd);
    end
    idle();
    #1;
    checks++;
    if (cpu_mem_ready_o !== 1'b0) begin
      errors++; $display("FAIL halt_single: got ready=%b want 0", cpu_mem_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int rdy;
    @(negedge clk_i);
    cpu_mem_valid_i = 1'b1;
    cpu_mem_addr_i  = 32'h0000_8020;
    cpu_mem_wdata_i = 32'h5555_AAAA;
    cpu_mem_wstrb_i = 4'hF;
    repeat (2) @(negedge clk_i);
    cpu_mem_valid_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({cpu_mem_ready_o, cpu_mem_rdata_o, bus_address_o, bus_addr_strb_o,
         bus_we_o, bus_we_ram_o, bus_data_o, err_o, err_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got nonzero output, want all 0");
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      #1;
      if (cpu_mem_ready_o) rdy++;
    end
    checks++;
    if (rdy !== 0) begin
      errors++; $display("FAIL reset_no_ready: got %0d pulses want 0", rdy);
    end
    bus_data_i = 32'h0000_4242;
    access(32'h0000_0100, 32'h0, 4'h0);
    checks++;
    if (lat !== 2 || rd !== 32'h4242) begin
      errors++;
      $display("FAIL reset_resume: got lat=%0d data=%h want 2/00004242", lat, rd);
    end
    idle();
  endtask

  initial begin
    reset_n_i       = 1'b0;
    cpu_mem_valid_i = 1'b0;
    cpu_mem_addr_i  = '0;
    cpu_mem_wdata_i = '0;
    cpu_mem_wstrb_i = '0;
    halt_i          = 1'b0;
    bus_data_i      = '0;
    bus_wait_i      = 1'b0;
    err_clr_i       = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_slow_back_to_back();
    test_wait();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
